// File: rtl/bram_cloud_loader.sv
// Streams x/y/z points into 128-bit BRAM words, publishes the point count header, then polls z word 0 for done.
// Define READBACK_EN to add the m_* stream that replays the filtered cloud after done.
module bram_cloud_loader #(
  parameter int N          = 16,
  parameter int LANES      = 8,
  parameter int DATA_BASE  = 1,
  parameter int MAX_POINTS = 4096,
  parameter int POLL_GAP   = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [N-1:0]   s_x,
  input  logic [N-1:0]   s_y,
  input  logic [N-1:0]   s_z,
  input  logic           s_last,
  output logic [31:0]    addr_x,
  output logic [31:0]    addr_y,
  output logic [31:0]    addr_z,
  output logic [127:0]   write_in_x,
  output logic [127:0]   write_in_y,
  output logic [127:0]   write_in_z,
  input  logic [127:0]   read_out_x,
  input  logic [127:0]   read_out_y,
  input  logic [127:0]   read_out_z,
  output logic           en_x,
  output logic           en_y,
  output logic           en_z,
  output logic           rst_x,
  output logic           rst_y,
  output logic           rst_z,
  output logic [15:0]    we_x,
  output logic [15:0]    we_y,
  output logic [15:0]    we_z,
  output logic           busy,
  output logic           cloud_done,
  output logic [31:0]    point_count
`ifdef READBACK_EN
  ,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N-1:0]   m_x,
  output logic [N-1:0]   m_y,
  output logic [N-1:0]   m_z,
  output logic           m_last
`endif
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(POLL_GAP + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [PW-1:0] GAP       = PW'(POLL_GAP);
  localparam logic [31:0]   BASE_ADDR = 32'(DATA_BASE);
  localparam logic [31:0]   MAX_CNT   = 32'(MAX_POINTS);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, HDR, POLL, DONE, RB} state_t;

  state_t          state_q, state_d;
  logic            init_q, init_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [127:0]    bx_q, bx_d, by_q, by_d, bz_q, bz_d;
  logic [31:0]     cnt_base;
  logic            is_last;
`ifdef READBACK_EN
  logic [31:0]     rb_idx_q, rb_idx_d;
  logic            bvalid_q, bvalid_d;
`else
  logic            unused_rd;
  assign unused_rd = ^{read_out_x, read_out_y, read_out_z[127:1]};
`endif

  assign rst_x       = 1'b0;
  assign rst_y       = 1'b0;
  assign rst_z       = 1'b0;
  assign point_count = cnt_q;

  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    lane_d  = lane_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    poll_d  = poll_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bz_d    = bz_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    cloud_done = 1'b0;
    addr_x = '0; addr_y = '0; addr_z = '0;
    write_in_x = '0; write_in_y = '0; write_in_z = '0;
    en_x = 1'b0; en_y = 1'b0; en_z = 1'b0;
    we_x = '0; we_y = '0; we_z = '0;
    cnt_base = cnt_q;
    is_last  = 1'b0;
`ifdef READBACK_EN
    rb_idx_d = rb_idx_q;
    bvalid_d = bvalid_q;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_x = '0; m_y = '0; m_z = '0;
`endif
    case (state_q)
      IDLE: begin
        s_ready  = init_q;
        cnt_base = '0;
      end
      FILL: begin
        s_ready = (cnt_q != MAX_CNT);
        busy    = 1'b1;
      end
      WRITE: begin
        busy = 1'b1;
        en_x = 1'b1; en_y = 1'b1; en_z = 1'b1;
        we_x = '1; we_y = '1; we_z = '1;
        addr_x = word_q; addr_y = word_q; addr_z = word_q;
        write_in_x = bx_q; write_in_y = by_q; write_in_z = bz_q;
        // Buffers are cleared after each write so a partial last word carries zero lanes.
        bx_d = '0; by_d = '0; bz_d = '0;
        lane_d  = '0;
        word_d  = word_q + 32'd1;
        state_d = last_q ? HDR : FILL;
      end
      HDR: begin
        busy = 1'b1;
        en_x = 1'b1; en_y = 1'b1; en_z = 1'b1;
        we_x = '1; we_y = '1; we_z = '1;
        write_in_x = {96'd0, cnt_q};
        write_in_y = {96'd0, cnt_q};
        poll_d  = '0;
        pend_d  = 1'b0;
        state_d = POLL;
      end
      POLL: begin
        busy = 1'b1;
        if (pend_q) begin
          pend_d = 1'b0;
          if (read_out_z[0]) state_d = DONE;
        end
        if (poll_q == GAP) begin
          en_z   = 1'b1;
          poll_d = '0;
          pend_d = 1'b1;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      DONE: begin
        cloud_done = 1'b1;
        word_d = BASE_ADDR;
        lane_d = '0;
        pend_d = 1'b0;
`ifdef READBACK_EN
        rb_idx_d = '0;
        bvalid_d = 1'b0;
        state_d  = RB;
`else
        state_d  = IDLE;
`endif
      end
`ifdef READBACK_EN
      RB: begin
        m_valid = bvalid_q;
        m_x = bx_q[N*lane_q +: N];
        m_y = by_q[N*lane_q +: N];
        m_z = bz_q[N*lane_q +: N];
        m_last = bvalid_q && (rb_idx_q == cnt_q - 32'd1);
        // The x/y/z pack buffers double as the readback skid word.
        if (pend_q) begin
          bx_d = read_out_x; by_d = read_out_y; bz_d = read_out_z;
          bvalid_d = 1'b1;
          pend_d   = 1'b0;
        end else if (!bvalid_q) begin
          en_x = 1'b1; en_y = 1'b1; en_z = 1'b1;
          addr_x = word_q; addr_y = word_q; addr_z = word_q;
          word_d = word_q + 32'd1;
          pend_d = 1'b1;
        end
        if (bvalid_q && m_ready) begin
          rb_idx_d = rb_idx_q + 32'd1;
          lane_d   = lane_q + 1'b1;
          if (m_last) begin
            bx_d = '0; by_d = '0; bz_d = '0;
            bvalid_d = 1'b0;
            lane_d   = '0;
            word_d   = BASE_ADDR;
            state_d  = IDLE;
          end else if (lane_q == LAST_LANE) begin
            bvalid_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (s_valid && s_ready) begin
      bx_d[N*lane_q +: N] = s_x;
      by_d[N*lane_q +: N] = s_y;
      bz_d[N*lane_q +: N] = s_z;
      cnt_d   = cnt_base + 32'd1;
      is_last = s_last || (cnt_d == MAX_CNT);
      last_d  = is_last;
      if (is_last || lane_q == LAST_LANE) begin
        state_d = WRITE;
      end else begin
        lane_d  = lane_q + 1'b1;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      lane_q  <= '0;
      word_q  <= BASE_ADDR;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      poll_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bz_q    <= '0;
`ifdef READBACK_EN
      rb_idx_q <= '0;
      bvalid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      poll_q  <= poll_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bz_q    <= bz_d;
`ifdef READBACK_EN
      rb_idx_q <= rb_idx_d;
      bvalid_q <= bvalid_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_cloud_loader.sv
// Directed bench for bram_cloud_loader: BRAM model with a delayed done flag, packing/header/saturation/reset checks.
module tb_bram_cloud_loader;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         s_valid, s_ready, s_last;
  logic [15:0]  s_x, s_y, s_z;
  logic [31:0]  addr_x, addr_y, addr_z;
  logic [127:0] write_in_x, write_in_y, write_in_z;
  logic [127:0] read_out_x, read_out_y, read_out_z;
  logic         en_x, en_y, en_z, rst_x, rst_y, rst_z;
  logic [15:0]  we_x, we_y, we_z;
  logic         busy, cloud_done;
  logic [31:0]  point_count;
`ifdef READBACK_EN
  logic         m_valid, m_ready, m_last;
  logic [15:0]  m_x, m_y, m_z;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  bram_cloud_loader #(.N(16), .LANES(8), .DATA_BASE(1), .MAX_POINTS(4096), .POLL_GAP(16)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
    .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .busy(busy), .cloud_done(cloud_done), .point_count(point_count)
`ifdef READBACK_EN
    , .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_last(m_last)
`endif
  );

  // BRAM model; the accelerator sets z word 0 bit 0 forty cycles after the header clears it.
  logic [127:0] mem_x [0:1023];
  logic [127:0] mem_y [0:1023];
  logic [127:0] mem_z [0:1023];
  logic [31:0]  wlog  [0:2047];
  logic [15:0]  rx_x  [0:4095];
  logic [15:0]  rx_z  [0:4095];
  int wr_cnt = 0;
  int zc_cnt = 0;
  int done_cnt = 0;
  int cd = 0;

  always @(posedge clock) begin
    if (en_x && we_x == 16'hffff) mem_x[addr_x[9:0]] <= write_in_x;
    if (en_y && we_y == 16'hffff) mem_y[addr_y[9:0]] <= write_in_y;
    if (en_z && we_z == 16'hffff && addr_z != 32'd0) mem_z[addr_z[9:0]] <= write_in_z;
    if (en_x && we_x == 16'hffff && addr_x != 32'd0) begin
      wlog[wr_cnt[10:0]] <= addr_x;
      wr_cnt <= wr_cnt + 1;
    end
    if (en_z && we_z == 16'hffff && addr_z == 32'd0) begin
      mem_z[0] <= write_in_z;
      if (write_in_z == 128'd0) zc_cnt <= zc_cnt + 1;
      cd <= 40;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) mem_z[0][0] <= 1'b1;
    end
    if (en_x && we_x == 16'h0000) read_out_x <= mem_x[addr_x[9:0]];
    if (en_y && we_y == 16'h0000) read_out_y <= mem_y[addr_y[9:0]];
    if (en_z && we_z == 16'h0000) read_out_z <= mem_z[addr_z[9:0]];
    if (cloud_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic last);
    int n = 0;
    s_valid = 1'b1; s_x = x; s_y = y; s_z = z; s_last = last;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    logic prev_busy = 1'b0;
    while (!cloud_done && n < 600) begin
      prev_busy = busy;
      tick();
      n++;
    end
    chk("done_seen", 32'(cloud_done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    chk("busy_high_before_done", 32'(prev_busy), 32'd1);
    tick();
  endtask

`ifdef READBACK_EN
  task automatic drain(input int n);
    int got = 0;
    int last_at = -1;
    for (int c = 0; c < 20000 && last_at < 0; c++) begin
      m_ready = c[0];
      if (m_valid && m_ready) begin
        if (got < 4096) begin
          rx_x[got] = m_x;
          rx_z[got] = m_z;
        end
        if (m_last) last_at = got;
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    chk("rb_count", got, n);
    chk("rb_last_at", last_at, n - 1);
    chk("rb_back_idle", 32'(s_ready), 32'd1);
  endtask
`endif

  task automatic finish_cloud(input int n);
    wait_done();
`ifdef READBACK_EN
    drain(n);
`else
    chk("pc_after_done", point_count, n);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, zb, db, rej;
    s_valid = 1'b0; s_last = 1'b0; s_x = '0; s_y = '0; s_z = '0;
`ifdef READBACK_EN
    m_ready = 1'b0;
`endif
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_en", 32'({en_x, en_y, en_z}), 32'd0);
    chk("rst_we", 32'(we_x | we_y | we_z), 32'd0);
    chk("rst_addr", addr_x | addr_y | addr_z, 32'd0);
    chk128("rst_wdata", write_in_x | write_in_y | write_in_z, 128'd0);
    chk("rst_bram_rst", 32'({rst_x, rst_y, rst_z}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cloud_done), 32'd0);
    chk("rst_count", point_count, 32'd0);
    reset = 1'b0;
    chk("ready_first_cycle", 32'(s_ready), 32'd0);
    tick();
    chk("ready_idle", 32'(s_ready), 32'd1);

    // Cloud A: exactly one full word.
    base = wr_cnt; zb = zc_cnt; db = done_cnt;
    for (int k = 1; k <= 8; k++)
      send(16'(k), 16'(16'h0100 + k), 16'(16'h0200 + k), k == 8);
    finish_cloud(8);
    repeat (2) tick();
    chk("a_writes", wr_cnt - base, 1);
    chk("a_addr", wlog[base], 32'd1);
    chk128("a_x1", mem_x[1], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk128("a_y1", mem_y[1], 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    chk128("a_z1", mem_z[1], 128'h0208_0207_0206_0205_0204_0203_0202_0201);
    chk128("a_hdr_x", mem_x[0], 128'd8);
    chk128("a_hdr_y", mem_y[0], 128'd8);
    chk("a_zclear", zc_cnt - zb, 1);
    chk("a_done_pulses", done_cnt - db, 1);

    // Cloud B: 11 points, second word partial.
    base = wr_cnt; zb = zc_cnt; db = done_cnt;
    for (int k = 1; k <= 11; k++) begin
      send(16'(16'h0010 + k), 16'(16'h0020 + k), 16'(16'h3000 + k), k == 11);
      if (k == 3) begin
        chk("b_busy_mid", 32'(busy), 32'd1);
        chk("b_count_mid", point_count, 32'd3);
      end
    end
    finish_cloud(11);
    repeat (2) tick();
    chk("b_writes", wr_cnt - base, 2);
    chk("b_addr0", wlog[base], 32'd1);
    chk("b_addr1", wlog[base + 1], 32'd2);
    chk128("b_x1", mem_x[1], 128'h0018_0017_0016_0015_0014_0013_0012_0011);
    chk128("b_x2", mem_x[2], 128'h0000_0000_0000_0000_0000_001b_001a_0019);
    chk128("b_y2", mem_y[2], 128'h0000_0000_0000_0000_0000_002b_002a_0029);
    chk128("b_z2", mem_z[2], 128'h0000_0000_0000_0000_0000_300b_300a_3009);
    chk128("b_hdr_x", mem_x[0], 128'd11);
    chk128("b_hdr_y", mem_y[0], 128'd11);
    chk("b_zclear", zc_cnt - zb, 1);
    chk("b_done_pulses", done_cnt - db, 1);
`ifdef READBACK_EN
    for (int i = 0; i < 11; i++) begin
      chk("b_rb_x", 32'(rx_x[i]), 32'(16'h0011 + i));
      chk("b_rb_z", 32'(rx_z[i]), 32'(16'h3001 + i));
    end
`endif

    // Reset in the middle of FILL.
    for (int k = 1; k <= 5; k++)
      send(16'(16'h0070 + k), 16'(16'h0070 + k), 16'(16'h0070 + k), 1'b0);
    chk("r_busy_before", 32'(busy), 32'd1);
    chk("r_count_before", point_count, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("r_s_ready", 32'(s_ready), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_count", point_count, 32'd0);
    chk("r_en", 32'({en_x, en_y, en_z}), 32'd0);
    chk("r_addr", addr_x, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    base = wr_cnt;
    for (int k = 1; k <= 8; k++)
      send(16'(16'h0040 + k), 16'(16'h0040 + k), 16'(16'h0040 + k), k == 8);
    finish_cloud(8);
    repeat (2) tick();
    chk("r_writes", wr_cnt - base, 1);
    chk("r_addr_restart", wlog[base], 32'd1);
    chk128("r_x1", mem_x[1], 128'h0048_0047_0046_0045_0044_0043_0042_0041);
    chk128("r_hdr_x", mem_x[0], 128'd8);

    // Saturation at MAX_POINTS.
    base = wr_cnt;
    for (int k = 1; k <= 4096; k++)
      send(16'(k), 16'(k), 16'(k), 1'b0);
    chk("s_count", point_count, 32'd4096);
    s_valid = 1'b1; s_x = 16'h1001; s_y = 16'h1001; s_z = 16'h1001;
    rej = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) rej++;
      tick();
    end
    s_valid = 1'b0;
    chk("s_ready_low", rej, 0);
    finish_cloud(4096);
    repeat (2) tick();
    chk("s_writes", wr_cnt - base, 512);
    chk("s_first_addr", wlog[base], 32'd1);
    chk("s_last_addr", wlog[base + 511], 32'd512);
    chk128("s_x512", mem_x[512], 128'h1000_0fff_0ffe_0ffd_0ffc_0ffb_0ffa_0ff9);
    chk128("s_hdr_x", mem_x[0], 128'd4096);
    chk("s_count_final", point_count, 32'd4096);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
